// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_pkg: shared state encoding and defaults for the pipeline hazard controller.
package pipeline_pkg;
    typedef enum logic {RUN, MDU_BUSY} hazard_state_e;
    localparam int MDU_LAT_DEFAULT = 4;
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs from ID/EX/MEM and stall/flush controls to the pipeline.
interface pipeline_hazard_ctrl_if;
    logic [4:0] rs1_id, rs2_id, rd_ex;
    logic       rs1_used_id, rs2_used_id;
    logic       mem_rd_ex, mdu_op_ex, branch_taken_ex;
    logic       dmem_req_mem, dmem_ack;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic       mdu_busy, mdu_done;
    modport master (
        output rs1_id, rs2_id, rd_ex, rs1_used_id, rs2_used_id, mem_rd_ex, mdu_op_ex,
               branch_taken_ex, dmem_req_mem, dmem_ack,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
               ex_mem_flush, mem_wb_flush, mdu_busy, mdu_done
    );
    modport slave (
        input  rs1_id, rs2_id, rd_ex, rs1_used_id, rs2_used_id, mem_rd_ex, mdu_op_ex,
               branch_taken_ex, dmem_req_mem, dmem_ack,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
               ex_mem_flush, mem_wb_flush, mdu_busy, mdu_done
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use.sv
// load_use_detect: flags an ID instruction reading the destination of a load sitting in EX.
module load_use_detect (
    input  logic [4:0] rs1_id_i,
    input  logic [4:0] rs2_id_i,
    input  logic [4:0] rd_ex_i,
    input  logic       rs1_used_id_i,
    input  logic       rs2_used_id_i,
    input  logic       mem_rd_ex_i,
    output logic       load_use_o
);
    assign load_use_o = mem_rd_ex_i & (rd_ex_i != 5'd0) &
                        ((rs1_used_id_i & (rs1_id_i == rd_ex_i)) |
                         (rs2_used_id_i & (rs2_id_i == rd_ex_i)));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for load-use, MDU occupancy, dmem waits and branches.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MDU_LAT = MDU_LAT_DEFAULT,
    parameter int CNT_W   = $clog2(MDU_LAT)
) (
    input logic                  clk,
    input logic                  rst_n,
    pipeline_hazard_ctrl_if.slave hz
);
    hazard_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use, mem_wait, mdu_stall;

    load_use_detect u_load_use (
        .rs1_id_i      (hz.rs1_id),
        .rs2_id_i      (hz.rs2_id),
        .rd_ex_i       (hz.rd_ex),
        .rs1_used_id_i (hz.rs1_used_id),
        .rs2_used_id_i (hz.rs2_used_id),
        .mem_rd_ex_i   (hz.mem_rd_ex),
        .load_use_o    (load_use)
    );

    assign mem_wait    = hz.dmem_req_mem & ~hz.dmem_ack;
    assign mdu_stall   = (state_q == RUN) ? hz.mdu_op_ex : (cnt_q != '0);
    assign hz.mdu_busy = (state_q == MDU_BUSY);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        hz.pc_en        = 1'b1;
        hz.if_id_en     = 1'b1;
        hz.id_ex_en     = 1'b1;
        hz.ex_mem_en    = 1'b1;
        hz.if_id_flush  = 1'b0;
        hz.id_ex_flush  = 1'b0;
        hz.ex_mem_flush = 1'b0;
        hz.mem_wb_flush = 1'b0;
        hz.mdu_done     = 1'b0;
        if (!rst_n) begin
            {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en} = 4'b0000;
            {hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush, hz.mem_wb_flush} = 4'b1111;
        end else if (mem_wait) begin
            // MDU keeps computing through a memory wait; only the advance is held.
            {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en} = 4'b0000;
            hz.mem_wb_flush = 1'b1;
            cnt_d = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        end else if (mdu_stall) begin
            {hz.pc_en, hz.if_id_en, hz.id_ex_en} = 3'b000;
            hz.ex_mem_flush = 1'b1;
            state_d = MDU_BUSY;
            cnt_d = (state_q == RUN) ? CNT_W'(MDU_LAT - 2) : cnt_q - CNT_W'(1);
        end else if (state_q == MDU_BUSY) begin
            hz.mdu_done = 1'b1;
            state_d = RUN;
        end else if (hz.branch_taken_ex) begin
            hz.if_id_flush = 1'b1;
            hz.id_ex_flush = 1'b1;
        end else if (load_use) begin
            hz.pc_en       = 1'b0;
            hz.if_id_en    = 1'b0;
            hz.id_ex_flush = 1'b1;
        end
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It sits beside the EX-stage forwarding logic and covers the hazards forwarding cannot resolve: load-use, multi-cycle MUL/DIV occupancy of EX, data-memory wait states and taken-branch squashing. It drives the enable and flush controls of the PC and all pipeline registers, and owns a small FSM plus a latency counter for the MUL/DIV unit (MDU).

## Interface
- `MDU_LAT`, default 4: total cycles an MDU instruction occupies EX; legal range 2..16.
- `CNT_W`, default `$clog2(MDU_LAT)`: width of the latency counter; not overridden by users.

- `clk`  in  1  pipeline clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rs1_id`, `rs2_id`  in  5 each  source registers of the instruction in ID.
- `rs1_used_id`, `rs2_used_id`  in  1 each  the ID instruction actually reads that source.
- `rd_ex`  in  5  destination register of the instruction in EX.
- `mem_rd_ex`  in  1  the instruction in EX is a load.
- `mdu_op_ex`  in  1  the instruction in EX is an MDU op (level).
- `branch_taken_ex`  in  1  the instruction in EX redirects the PC.
- `dmem_req_mem`  in  1  the instruction in MEM has an outstanding data-memory request.
- `dmem_ack`  in  1  the data memory completes the request this cycle.
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`  out  1 each  register load enables.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`, `mem_wb_flush`  out  1 each  load a NOP bubble.
- `mdu_busy`  out  1  state is MDU_BUSY.
- `mdu_done`  out  1  single-cycle pulse on the cycle the MDU result advances out of EX.

## Operation
- States: RUN, MDU_BUSY. Outputs are combinational from state, counter and inputs.
- `mem_wait = dmem_req_mem & ~dmem_ack`. This condition has highest priority in every state.
  - All four enables are 0.
  - `mem_wb_flush` is 1; every other flush is 0.
  - No state transition occurs, except that the counter continues to decrement.
- Default in RUN: all enables 1 and all flushes 0.
- Load-use, RUN only, when not `mem_wait`:
  - Condition: `mem_rd_ex & rd_ex!=0 & ((rs1_used_id & rs1_id==rd_ex) | (rs2_used_id & rs2_id==rd_ex))`.
  - Response: `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1.
- Branch, when `branch_taken_ex` and `ex_mem_en`=1: `if_id_flush`=1 and `id_ex_flush`=1.
  - Branch flush overrides a load-use stall; `pc_en` remains 1 so the redirect loads.
- MDU entry, RUN when `mdu_op_ex` and not `mem_wait`:
  - `pc_en`, `if_id_en`, `id_ex_en` are 0; `ex_mem_flush`=1.
  - Counter loads `MDU_LAT-2`; next state is MDU_BUSY.
- MDU_BUSY with counter != 0:
  - Same freeze and `ex_mem_flush` as entry.
  - Counter decrements.
- MDU_BUSY with counter == 0 and not `mem_wait`:
  - Release: all enables 1, `mdu_done`=1, next state RUN.
  - `mdu_op_ex` is ignored in this cycle.
- MDU_BUSY with counter == 0 and `mem_wait`: hold at 0 in MDU_BUSY until the wait clears.

## Timing
- An MDU instruction occupies EX for exactly `MDU_LAT` cycles when there is no memory wait: `MDU_LAT-1` stall cycles, then the advance cycle.
- Each memory-wait cycle extends the MDU occupancy only if it occurs after the counter reaches 0.
- Load-use costs exactly 1 bubble cycle. A taken branch costs 2 squashed slots.
- While `rst_n`=0:
  - All enables are 0, all flushes are 1, and `mdu_busy`/`mdu_done` are 0.
  - State is RUN and the counter is 0.
- Reset mid-MDU aborts the operation. The first cycle after release follows RUN rules.
- `dmem_ack` without `dmem_req_mem` is ignored.

## Structure
- `pipeline_pkg` holds the `hazard_state_e` enum {RUN, MDU_BUSY} and the `MDU_LAT_DEFAULT` constant.
- One combinational sub-module, `load_use_detect`, contains the comparator term.
- The FSM, counter and output priority mux stay in the top module.

## Test plan
- Load-use: `mem_rd_ex`=1, `rd_ex`=5, `rs1_id`=5, `rs1_used_id`=1 -> one cycle with `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1. Same stimulus with `rd_ex`=0 -> no stall.
- MDU with `MDU_LAT`=4: `mdu_op_ex` held high -> `id_ex_en`=0 for 3 cycles, then `mdu_done`=1 for 1 cycle, then RUN. Repeat with `MDU_LAT`=2 -> 1 stall cycle.
- Memory wait: `dmem_req_mem`=1 and `dmem_ack`=0 for 3 cycles -> all enables 0 and `mem_wb_flush`=1 for 3 cycles; the ack cycle returns to normal.
- Branch concurrent with load-use -> `if_id_flush`=1, `id_ex_flush`=1, `pc_en`=1. Branch during memory wait -> flush is deferred to the ack cycle.
- MDU overlapping memory wait: wait begins with the counter at 0 and lasts 2 cycles -> `mdu_done` is delayed 2 cycles.
- Reset: `rst_n` low on the 2nd MDU_BUSY cycle -> immediately `mdu_busy`=0, all flushes 1; after release, RUN defaults apply.
